// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: single-outstanding imem requests feeding a small instruction buffer
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;

  logic [XLEN-1:0] r_buf_data [DEPTH];
  logic [XLEN-1:0] r_buf_pc   [DEPTH];
  logic [AW-1:0]   r_rptr;
  logic [AW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;

  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;

  // A request only issues with no response outstanding and a free buffer
  // slot, so the returning response can always be pushed.
  assign imem_req_valid = !rst && (r_state == S_REQ) && (r_count < DEPTH_C);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Redirect flushes the buffer, so it suppresses both push and pop.
  assign w_push         = (r_state == S_WAIT) && imem_resp_valid && !redirect_valid;
  assign w_pop          = inst_valid && inst_ready && !redirect_valid;
  assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};

  assign inst_valid     = (r_count != '0);
  assign inst_data      = r_buf_data[r_rptr];
  assign inst_pc        = r_buf_pc[r_rptr];

  // Fetch FSM: tracks the outstanding request and whether its response is still wanted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      case (r_state)
        S_REQ:   r_state <= w_req_fire ? S_DROP : S_REQ;
        S_WAIT,
        S_DROP:  r_state <= imem_resp_valid ? S_REQ : S_DROP;
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_req_fire) begin
            r_state    <= S_WAIT;
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Instruction buffer: circular FIFO of {pc, data}, flushed on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wptr] <= imem_resp_data;
        r_buf_pc[r_wptr]   <= r_req_pc;
        r_wptr             <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/instruction width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 imem_resp_valid  input  1  response data valid this cycle.
REQ-010 imem_resp_data  input  XLEN  instruction word returned.
REQ-011 redirect_valid  input  1  branch/jump/trap redirect, single-cycle pulse.
REQ-012 redirect_pc  input  XLEN  redirect target.
REQ-013 inst_valid  output  1  buffered instruction available to decode.
REQ-014 inst_ready  input  1  decode consumes head this cycle.
REQ-015 inst_data  output  XLEN  head instruction word.
REQ-016 inst_pc  output  XLEN  PC of head instruction.

Function
REQ-017 FSM states: REQ (request may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-018 Request handshake = imem_req_valid && imem_req_ready; response handshake = imem_resp_valid; at most one request outstanding.
REQ-019 imem_req_valid asserted only in REQ and only when buffer count + 0 outstanding < DEPTH (slot reserved before issue).
REQ-020 imem_req_addr = fetch_pc; fetch_pc and imem_req_addr stable while valid && !ready, except on redirect.
REQ-021 REQ -> WAIT on request handshake; fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN (FFFF_FFFC -> 0000_0000).
REQ-022 WAIT -> REQ on imem_resp_valid; {pc of request, imem_resp_data} pushed to buffer same edge; response ignored in REQ.
REQ-023 Minimum latency: response accepted no earlier than cycle after request handshake; inst_valid asserts cycle after response.
REQ-024 inst_valid = buffer non-empty; inst_data/inst_pc = head entry; pop on inst_valid && inst_ready.
REQ-025 Push and pop same cycle: both take effect, count unchanged; no push when full (prevented by REQ-019).
REQ-026 Redirect (highest priority): buffer flushed, count <= 0, fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
REQ-027 Redirect in REQ without handshake -> stay REQ, new address next cycle; with handshake same cycle -> DROP.
REQ-028 Redirect in WAIT with no response -> DROP; with response same cycle -> response discarded, go REQ.
REQ-029 Redirect in DROP -> stay DROP (or REQ if response same cycle), fetch_pc updated.
REQ-030 DROP -> REQ on imem_resp_valid; data discarded, no push; no request issued while in DROP.
REQ-031 Pop coinciding with redirect is ignored (flush wins); inst_valid 0 cycle after redirect.

Reset
REQ-032 During rst: state REQ, fetch_pc = RESET_PC, count 0, imem_req_valid 0, inst_valid 0, imem_req_addr = RESET_PC, inst_data/inst_pc 0.
REQ-033 First cycle after rst deasserts: imem_req_valid 1, imem_req_addr = RESET_PC.
REQ-034 rst mid-operation discards outstanding request; a late response arriving in REQ after reset is ignored.

Verification
REQ-035 Reset release, ready=1, 1-cycle response latency, inst_ready=1 -> inst_pc sequence 0,4,8,C with matching data.
REQ-036 inst_ready=0 -> exactly DEPTH (2) instructions buffered, imem_req_valid stays 0, no data lost after ready returns.
REQ-037 imem_req_ready=0 for 3 cycles -> addr held at 0x8 throughout, fetch_pc advances only on acceptance.
REQ-038 Redirect to 0x1003 while WAIT, response next cycle -> response dropped, next request addr 0x1000, first inst_pc 0x1000.
REQ-039 Redirect same cycle as response and pop -> buffer empty next cycle, no stale instruction emitted.
REQ-040 fetch_pc 0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
